// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear sequencer. Owns the min:sec.cs time registers,
// the lap snapshot, the sticky wrap flag and the prescaler enable/clear.
// Every output is taken from a register; the registered values are computed
// from the next-state values so a button takes effect one cycle later.
module stopwatch_ctrl #(
  parameter int unsigned CS_MAX  = 99,
  parameter int unsigned SEC_MAX = 59,
  parameter int unsigned MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic       tick,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [5:0] disp_min,
  output logic [5:0] disp_sec,
  output logic [6:0] disp_cs,
  output logic       ovf,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam logic [6:0] CS_LAST  = 7'(CS_MAX);
  localparam logic [5:0] SEC_LAST = 6'(SEC_MAX);
  localparam logic [5:0] MIN_LAST = 6'(MIN_MAX);

  state_t     state_q, state_d;
  logic [5:0] min_q, min_d, sec_q, sec_d;
  logic [6:0] cs_q, cs_d;
  logic [5:0] lap_min_q, lap_min_d, lap_sec_q, lap_sec_d;
  logic [6:0] lap_cs_q, lap_cs_d;
  logic       ovf_q, ovf_d;
  logic       cnt_en_q, cnt_en_d, cnt_clr_q, cnt_clr_d;
  logic [5:0] disp_min_q, disp_min_d, disp_sec_q, disp_sec_d;
  logic [6:0] disp_cs_q, disp_cs_d;

  logic [5:0] inc_min, inc_sec;
  logic [6:0] inc_cs;
  logic       inc_wrap;
  logic       counting;

  // Time plus one centisecond, with the full carry chain resolved in one cycle.
  always_comb begin
    inc_cs   = cs_q;
    inc_sec  = sec_q;
    inc_min  = min_q;
    inc_wrap = 1'b0;
    if (cs_q == CS_LAST) begin
      inc_cs = 7'd0;
      if (sec_q == SEC_LAST) begin
        inc_sec = 6'd0;
        if (min_q == MIN_LAST) begin
          inc_min  = 6'd0;
          inc_wrap = 1'b1;
        end else begin
          inc_min = min_q + 6'd1;
        end
      end else begin
        inc_sec = sec_q + 6'd1;
      end
    end else begin
      inc_cs = cs_q + 7'd1;
    end
  end

  // Ticks only count while the registered state is RUN or LAP.
  assign counting = tick && ((state_q == RUN) || (state_q == LAP));

  // Next state, time/lap/flag updates and the registered output values.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    cs_d      = cs_q;
    lap_min_d = lap_min_q;
    lap_sec_d = lap_sec_q;
    lap_cs_d  = lap_cs_q;
    ovf_d     = ovf_q;

    if (counting) begin
      min_d = inc_min;
      sec_d = inc_sec;
      cs_d  = inc_cs;
      if (inc_wrap) ovf_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        min_d = 6'd0;
        sec_d = 6'd0;
        cs_d  = 7'd0;
        ovf_d = 1'b0;
        if (btn_ss) state_d = RUN;
      end
      RUN: begin
        if (btn_ss) begin
          state_d = PAUSE;
        end else if (btn_lr) begin
          // Snapshot includes an increment landing in this same cycle.
          state_d   = LAP;
          lap_min_d = min_d;
          lap_sec_d = sec_d;
          lap_cs_d  = cs_d;
        end
      end
      LAP: begin
        if (btn_ss)      state_d = PAUSE;
        else if (btn_lr) state_d = RUN;
      end
      PAUSE: begin
        if (btn_ss) begin
          state_d = RUN;
        end else if (btn_lr) begin
          state_d = IDLE;
          min_d   = 6'd0;
          sec_d   = 6'd0;
          cs_d    = 7'd0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    cnt_en_d  = (state_d == RUN) || (state_d == LAP);
    cnt_clr_d = (state_d == IDLE);
    if (state_d == LAP) begin
      disp_min_d = lap_min_d;
      disp_sec_d = lap_sec_d;
      disp_cs_d  = lap_cs_d;
    end else begin
      disp_min_d = min_d;
      disp_sec_d = sec_d;
      disp_cs_d  = cs_d;
    end
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      cs_q       <= 7'd0;
      lap_min_q  <= 6'd0;
      lap_sec_q  <= 6'd0;
      lap_cs_q   <= 7'd0;
      ovf_q      <= 1'b0;
      cnt_en_q   <= 1'b0;
      cnt_clr_q  <= 1'b1;
      disp_min_q <= 6'd0;
      disp_sec_q <= 6'd0;
      disp_cs_q  <= 7'd0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      cs_q       <= cs_d;
      lap_min_q  <= lap_min_d;
      lap_sec_q  <= lap_sec_d;
      lap_cs_q   <= lap_cs_d;
      ovf_q      <= ovf_d;
      cnt_en_q   <= cnt_en_d;
      cnt_clr_q  <= cnt_clr_d;
      disp_min_q <= disp_min_d;
      disp_sec_q <= disp_sec_d;
      disp_cs_q  <= disp_cs_d;
    end
  end

  assign state    = state_q;
  assign cnt_en   = cnt_en_q;
  assign cnt_clr  = cnt_clr_q;
  assign disp_min = disp_min_q;
  assign disp_sec = disp_sec_q;
  assign disp_cs  = disp_cs_q;
  assign ovf      = ovf_q;

endmodule
